adc_scan_scheduler: RTL and testbench

//  Sequences the 8-channel ADC serial interface: picks the channel for each
//  16-clk conversion frame (round-robin over an enable mask) and tags each

---
 rtl/adc_scan_scheduler.sv | 181 ++++++++++++++++++
 tb/tb_adc_scan_scheduler.sv | 391 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_scan_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : adc_scan_scheduler
// Description : Round-robin channel scheduler for a framed 8-channel ADC,
//               tagging each returned result with its channel.
// Revision    : 1.0
// ============================================================================
module adc_scan_scheduler #(
  parameter int LATENCY = 2,
  parameter int NCHAN   = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NCHAN-1:0]         enable_mask,
  input  logic                     start,
  input  logic                     continuous,
  input  logic                     adc_convst,
  input  logic signed [11:0]       adc_result,
  output logic [$clog2(NCHAN)-1:0] chan,
  output logic                     sample_valid,
  output logic [$clog2(NCHAN)-1:0] sample_chan,
  output logic signed [11:0]       sample_data,
  input  logic [$clog2(NCHAN)-1:0] rd_chan,
  output logic signed [11:0]       rd_data,
  output logic                     rd_valid,
  output logic                     busy,
  output logic                     sweep_done
);

  localparam int CW = $clog2(NCHAN);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t               r_state;
  logic                 r_convst_q;
  logic [NCHAN-1:0]     r_smask;
  logic [CW-1:0]        r_chan;
  logic [LATENCY-1:0]   r_pv;
  logic [LATENCY-1:0]   r_pl;
  logic [CW-1:0]        r_pc [LATENCY];
  logic signed [11:0]   r_mem [NCHAN];
  logic [NCHAN-1:0]     r_wvalid;
  logic                 r_sample_valid;
  logic [CW-1:0]        r_sample_chan;
  logic signed [11:0]   r_sample_data;
  logic signed [11:0]   r_rd_data;
  logic                 r_rd_valid;
  logic                 r_busy;
  logic                 r_sweep_done;

  logic                 w_tick;
  logic                 w_issue;
  logic                 w_last;
  logic                 w_pipe_empty_after;

  function automatic logic [CW-1:0] f_lowest(input logic [NCHAN-1:0] m);
    f_lowest = '0;
    for (int i = NCHAN - 1; i >= 0; i--)
      if (m[i]) f_lowest = CW'(i);
  endfunction

  function automatic logic [CW-1:0] f_highest(input logic [NCHAN-1:0] m);
    f_highest = '0;
    for (int i = 0; i < NCHAN; i++)
      if (m[i]) f_highest = CW'(i);
  endfunction

  function automatic logic [CW-1:0] f_next_above(input logic [NCHAN-1:0] m,
                                                 input logic [CW-1:0]    c);
    f_next_above = c;
    for (int i = NCHAN - 1; i >= 0; i--)
      if (m[i] && (i > int'(c))) f_next_above = CW'(i);
  endfunction

  assign w_tick  = adc_convst & ~r_convst_q;
  assign w_issue = (r_state == S_RUN);
  assign w_last  = (r_chan == f_highest(r_smask));

  // After a shift, stage 0 takes an invalid tag outside RUN, so only the
  // older stages that move up can keep the pipe occupied.
  always_comb begin
    w_pipe_empty_after = 1'b1;
    for (int i = 0; i < LATENCY - 1; i++)
      if (r_pv[i]) w_pipe_empty_after = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_convst_q     <= 1'b0;
      r_smask        <= '0;
      r_chan         <= '0;
      r_pv           <= '0;
      r_pl           <= '0;
      for (int i = 0; i < LATENCY; i++) r_pc[i] <= '0;
      for (int i = 0; i < NCHAN; i++) r_mem[i] <= '0;
      r_wvalid       <= '0;
      r_sample_valid <= 1'b0;
      r_sample_chan  <= '0;
      r_sample_data  <= '0;
      r_rd_data      <= '0;
      r_rd_valid     <= 1'b0;
      r_busy         <= 1'b0;
      r_sweep_done   <= 1'b0;
    end else begin
      r_convst_q     <= adc_convst;
      r_sample_valid <= 1'b0;
      r_sweep_done   <= 1'b0;
      r_rd_data      <= r_mem[rd_chan];
      r_rd_valid     <= r_wvalid[rd_chan];

      if (w_tick) begin
        r_pv[0] <= w_issue;
        r_pl[0] <= w_issue & w_last;
        r_pc[0] <= r_chan;
        for (int i = 1; i < LATENCY; i++) begin
          r_pv[i] <= r_pv[i-1];
          r_pl[i] <= r_pl[i-1];
          r_pc[i] <= r_pc[i-1];
        end
        if (r_pv[LATENCY-1]) begin
          r_mem[r_pc[LATENCY-1]]    <= adc_result;
          r_wvalid[r_pc[LATENCY-1]] <= 1'b1;
          r_sample_valid            <= 1'b1;
          r_sample_chan             <= r_pc[LATENCY-1];
          r_sample_data             <= adc_result;
          r_sweep_done              <= r_pl[LATENCY-1];
        end
      end

      case (r_state)
        S_IDLE: begin
          if ((start || continuous) && (|enable_mask)) begin
            r_smask <= enable_mask;
            r_chan  <= f_lowest(enable_mask);
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          if (w_tick) begin
            if (!w_last) begin
              r_chan <= f_next_above(r_smask, r_chan);
            end else if (continuous && (|enable_mask)) begin
              r_smask <= enable_mask;
              r_chan  <= f_lowest(enable_mask);
            end else begin
              r_chan <= f_lowest(r_smask);
              if (!continuous) r_state <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (w_tick && w_pipe_empty_after) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign chan         = r_chan;
  assign sample_valid = r_sample_valid;
  assign sample_chan  = r_sample_chan;
  assign sample_data  = r_sample_data;
  assign rd_data      = r_rd_data;
  assign rd_valid     = r_rd_valid;
  assign busy         = r_busy;
  assign sweep_done   = r_sweep_done;

endmodule
`default_nettype wire

// File: tb/tb_adc_scan_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_adc_scan_scheduler
// Description : Self-checking bench; ADC frame model plus sample scoreboard.
// Revision    : 1.0
// ============================================================================
module tb_adc_scan_scheduler;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic [7:0]         enable_mask = '0;
  logic               start = 1'b0;
  logic               continuous = 1'b0;
  logic               adc_convst;
  logic signed [11:0] adc_result;
  logic [2:0]         chan;
  logic               sample_valid;
  logic [2:0]         sample_chan;
  logic signed [11:0] sample_data;
  logic [2:0]         rd_chan = '0;
  logic signed [11:0] rd_data;
  logic               rd_valid;
  logic               busy;
  logic               sweep_done;

  int n_cmp = 0;
  int n_bad = 0;
  int fc = 15;
  int tick_no = 0;

  logic [14:0] sb[$];
  int ob_tick[$];
  int ob_chan[$];
  int done_ticks[$];

  adc_scan_scheduler #(.LATENCY(2), .NCHAN(8)) dut (
    .clk(clk), .reset(reset), .enable_mask(enable_mask), .start(start),
    .continuous(continuous), .adc_convst(adc_convst), .adc_result(adc_result),
    .chan(chan), .sample_valid(sample_valid), .sample_chan(sample_chan),
    .sample_data(sample_data), .rd_chan(rd_chan), .rd_data(rd_data),
    .rd_valid(rd_valid), .busy(busy), .sweep_done(sweep_done)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] rval(input int k);
    rval = 12'((k * 733 + 91) & 4095);
  endfunction

  // ADC interface model: one CONVST per 16 clocks, fresh result each frame
  initial begin
    adc_convst = 1'b0;
    adc_result = '0;
    forever begin
      @(negedge clk);
      fc = (fc == 15) ? 0 : fc + 1;
      adc_convst = (fc == 0);
      if (fc == 0) begin
        tick_no++;
        adc_result = rval(tick_no);
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && sample_valid) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL sample_unexpected got chan=%0d data=%0d", sample_chan, sample_data);
      end else begin
        logic [14:0] e;
        e = sb.pop_front();
        if ({sample_chan, sample_data} !== e) begin
          n_bad++;
          $display("FAIL sample got chan=%0d data=%0d exp chan=%0d data=%0d",
                   sample_chan, sample_data, e[14:12], e[11:0]);
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic to_mid();
    do step(); while (fc != 4);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic clear_obs();
    ob_tick.delete();
    ob_chan.delete();
    done_ticks.delete();
  endtask

  task automatic observe(input int until_tick);
    int guard;
    guard = 0;
    while (!(tick_no == until_tick && fc == 4) && guard < 4000) begin
      step();
      guard++;
      if (adc_convst && fc == 0) begin
        ob_tick.push_back(tick_no);
        ob_chan.push_back(int'(chan));
      end
      if (sweep_done) done_ticks.push_back(tick_no);
    end
    if (guard >= 4000) begin
      n_cmp++;
      n_bad++;
      $display("FAIL observe_timeout got tick=%0d exp tick=%0d", tick_no, until_tick);
    end
  endtask

  function automatic int chan_at(input int k);
    chan_at = -1;
    foreach (ob_tick[i]) if (ob_tick[i] == k) chan_at = ob_chan[i];
  endfunction

  function automatic int done_at(input int i);
    done_at = (i < done_ticks.size()) ? done_ticks[i] : -1;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) step();
    n_cmp++;
    if ({chan, sample_valid, sample_chan, sample_data} !== 19'd0) begin
      n_bad++;
      $display("FAIL reset_outputs got chan=%0d sv=%0d sc=%0d sd=%0d exp all 0",
               chan, sample_valid, sample_chan, sample_data);
    end
    n_cmp++;
    if ({rd_data, rd_valid, busy, sweep_done} !== 15'd0) begin
      n_bad++;
      $display("FAIL reset_status got rd_data=%0d rd_valid=%0d busy=%0d done=%0d exp all 0",
               rd_data, rd_valid, busy, sweep_done);
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_sweep();
    int k0;
    clear_obs();
    enable_mask = 8'h05;
    to_mid();
    k0 = tick_no + 1;
    pulse_start();
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL sweep_busy got=%0d exp=1", busy);
    end
    sb.push_back({3'd0, rval(k0 + 2)});
    sb.push_back({3'd2, rval(k0 + 3)});
    observe(k0 + 5);
    n_cmp++;
    if (chan_at(k0) != 0 || chan_at(k0 + 1) != 2) begin
      n_bad++;
      $display("FAIL sweep_chan got=%0d,%0d exp=0,2", chan_at(k0), chan_at(k0 + 1));
    end
    n_cmp++;
    if (done_ticks.size() != 1 || done_at(0) != k0 + 3) begin
      n_bad++;
      $display("FAIL sweep_done got n=%0d tick=%0d exp n=1 tick=%0d",
               done_ticks.size(), done_at(0), k0 + 3);
    end
    n_cmp++;
    if (busy !== 1'b0 || sb.size() != 0) begin
      n_bad++;
      $display("FAIL sweep_end got busy=%0d pending=%0d exp busy=0 pending=0", busy, sb.size());
    end
  endtask

  task automatic test_continuous();
    int k0;
    int exp_c[4] = '{0, 7, 0, 7};
    clear_obs();
    enable_mask = 8'h81;
    to_mid();
    k0 = tick_no + 1;
    continuous = 1'b1;
    for (int i = 0; i < 4; i++) sb.push_back({3'(exp_c[i]), rval(k0 + i + 2)});
    observe(k0 + 2);
    continuous = 1'b0;
    observe(k0 + 7);
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (chan_at(k0 + i) != exp_c[i]) begin
        n_bad++;
        $display("FAIL cont_chan[%0d] got=%0d exp=%0d", i, chan_at(k0 + i), exp_c[i]);
      end
    end
    n_cmp++;
    if (done_ticks.size() != 2 || done_at(0) != k0 + 3 || done_at(1) != k0 + 5) begin
      n_bad++;
      $display("FAIL cont_done got n=%0d t0=%0d t1=%0d exp n=2 t0=%0d t1=%0d",
               done_ticks.size(), done_at(0), done_at(1), k0 + 3, k0 + 5);
    end
    n_cmp++;
    if (busy !== 1'b0 || sb.size() != 0) begin
      n_bad++;
      $display("FAIL cont_end got busy=%0d pending=%0d exp busy=0 pending=0", busy, sb.size());
    end
  endtask

  task automatic test_mask_zero();
    clear_obs();
    enable_mask = 8'h00;
    to_mid();
    pulse_start();
    step();
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL zero_busy got=%0d exp=0", busy);
    end
    observe(tick_no + 3);
    n_cmp++;
    if (busy !== 1'b0 || done_ticks.size() != 0) begin
      n_bad++;
      $display("FAIL zero_idle got busy=%0d dones=%0d exp busy=0 dones=0", busy, done_ticks.size());
    end
  endtask

  task automatic test_mask_change();
    int k0;
    clear_obs();
    enable_mask = 8'h0F;
    to_mid();
    k0 = tick_no + 1;
    continuous = 1'b1;
    for (int i = 0; i < 8; i++) sb.push_back({3'(i), rval(k0 + i + 2)});
    observe(k0);
    enable_mask = 8'hF0;
    observe(k0 + 5);
    continuous = 1'b0;
    observe(k0 + 10);
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (chan_at(k0 + i) != i) begin
        n_bad++;
        $display("FAIL mchg_chan[%0d] got=%0d exp=%0d", i, chan_at(k0 + i), i);
      end
    end
    n_cmp++;
    if (done_ticks.size() != 2 || done_at(0) != k0 + 5 || done_at(1) != k0 + 9) begin
      n_bad++;
      $display("FAIL mchg_done got n=%0d t0=%0d t1=%0d exp n=2 t0=%0d t1=%0d",
               done_ticks.size(), done_at(0), done_at(1), k0 + 5, k0 + 9);
    end
    n_cmp++;
    if (busy !== 1'b0 || sb.size() != 0) begin
      n_bad++;
      $display("FAIL mchg_end got busy=%0d pending=%0d exp busy=0 pending=0", busy, sb.size());
    end
  endtask

  task automatic test_single();
    int k0;
    clear_obs();
    enable_mask = 8'h08;
    to_mid();
    k0 = tick_no + 1;
    pulse_start();
    sb.push_back({3'd3, rval(k0 + 2)});
    observe(k0 + 4);
    n_cmp++;
    if (chan_at(k0) != 3 || done_ticks.size() != 1 || done_at(0) != k0 + 2) begin
      n_bad++;
      $display("FAIL single got chan=%0d dones=%0d tick=%0d exp chan=3 dones=1 tick=%0d",
               chan_at(k0), done_ticks.size(), done_at(0), k0 + 2);
    end
    n_cmp++;
    if (busy !== 1'b0 || sb.size() != 0) begin
      n_bad++;
      $display("FAIL single_end got busy=%0d pending=%0d exp busy=0 pending=0", busy, sb.size());
    end
  endtask

  task automatic test_read_port();
    int k0;
    clear_obs();
    enable_mask = 8'hFF;
    to_mid();
    k0 = tick_no + 1;
    pulse_start();
    for (int i = 0; i < 8; i++) sb.push_back({3'(i), rval(k0 + i + 2)});
    observe(k0 + 2);
    pulse_start();
    observe(k0 + 11);
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (chan_at(k0 + i) != i) begin
        n_bad++;
        $display("FAIL ff_chan[%0d] got=%0d exp=%0d", i, chan_at(k0 + i), i);
      end
    end
    n_cmp++;
    if (done_ticks.size() != 1 || done_at(0) != k0 + 9 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL ff_done got n=%0d tick=%0d busy=%0d exp n=1 tick=%0d busy=0",
               done_ticks.size(), done_at(0), busy, k0 + 9);
    end
    rd_chan = 3'd5;
    step();
    step();
    n_cmp++;
    if (rd_data !== rval(k0 + 7) || rd_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL rd_ch5 got data=%0d valid=%0d exp data=%0d valid=1",
               rd_data, rd_valid, rval(k0 + 7));
    end
    rd_chan = 3'd2;
    step();
    step();
    n_cmp++;
    if (rd_data !== rval(k0 + 4) || rd_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL rd_ch2 got data=%0d valid=%0d exp data=%0d valid=1",
               rd_data, rd_valid, rval(k0 + 4));
    end
  endtask

  task automatic test_reset_inflight();
    int k0;
    clear_obs();
    enable_mask = 8'hFF;
    to_mid();
    k0 = tick_no + 1;
    pulse_start();
    observe(k0 + 1);
    reset = 1'b1;
    repeat (3) step();
    sb.delete();
    reset = 1'b0;
    step();
    n_cmp++;
    if (busy !== 1'b0 || chan !== 3'd0 || sample_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_mid got busy=%0d chan=%0d sv=%0d exp 0,0,0", busy, chan, sample_valid);
    end
    clear_obs();
    observe(tick_no + 4);
    n_cmp++;
    if (done_ticks.size() != 0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_quiet got dones=%0d busy=%0d exp dones=0 busy=0", done_ticks.size(), busy);
    end
    for (int i = 0; i < 8; i++) begin
      rd_chan = 3'(i);
      step();
      step();
      n_cmp++;
      if (rd_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL rst_rd_valid[%0d] got=%0d exp=0", i, rd_valid);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_sweep();
    test_continuous();
    test_mask_zero();
    test_mask_change();
    test_single();
    test_read_port();
    test_reset_inflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
